// File: rtl/imem_boot_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
//   boot_state_t    : loader FSM states
//   HDR_BYTES       : bytes in the little-endian word-count header
//   BYTES_PER_WORD  : payload bytes packed into one text word
package rv32_boot_pkg;

    typedef enum logic [2:0] {
        HDR,
        CHECK,
        DATA,
        DONE,
        ERR
    } boot_state_t;

    localparam int HDR_BYTES      = 4;
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-stream input and text-memory write port of the boot loader.
//   in_valid/in_ready/in_data : byte stream, transfer on valid && ready
//   mem_wen/mem_addr/mem_wdata: one-cycle text memory write
// master: stream source / memory side (environment)
// slave : the loader
interface imem_boot_loader_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;

    modport master (
        output in_valid, in_data,
        input  in_ready, mem_wen, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_wen, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_boot_loader_packer.sv
// Little-endian byte-to-word packer, shared by the header and the payload.
//   clk, rst_n  : clock, asynchronous active-low reset
//   byte_en     : a byte is transferred this cycle
//   byte_in     : the byte
//   word_valid  : this byte completes a word (combinational)
//   word        : completed word including byte_in (valid with word_valid)
module rv32_word_packer
    import rv32_boot_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [31:0] shreg_q, shreg_d;

    // Bytes enter at the top and shift down, so after four bytes the first
    // one sits in [7:0]. The index wraps to 0 on its own after the 4th byte.
    always_comb begin
        byte_idx_d = byte_idx_q;
        shreg_d    = shreg_q;
        if (byte_en) begin
            shreg_d    = {byte_in, shreg_q[31:8]};
            byte_idx_d = byte_idx_q + 2'd1;
        end
    end

    assign word_valid = byte_en && (byte_idx_q == 2'(BYTES_PER_WORD - 1));
    assign word       = {byte_in, shreg_q[31:8]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_idx_q <= '0;
            shreg_q    <= '0;
        end else begin
            byte_idx_q <= byte_idx_d;
            shreg_q    <= shreg_d;
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Instruction-memory boot loader: receives a 32-bit word count N followed by
// 4*N payload bytes, writes the packed words from OFFSET upward and then
// releases the core from reset.
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus         : byte stream in, text memory write port out (slave modport)
//   core_rst_n  : active-low core reset, released once the image is written
//   load_done   : image complete (sticky)
//   load_err    : N exceeded DEPTH_WORDS (sticky)
module imem_boot_loader
    import rv32_boot_pkg::*;
#(
    parameter logic [31:0] OFFSET      = 32'h8000_0000,
    parameter int unsigned DEPTH_WORDS = 4096
) (
    input  logic                clk,
    input  logic                rst_n,
    imem_boot_loader_if.slave   bus,
    output logic                core_rst_n,
    output logic                load_done,
    output logic                load_err
);

    boot_state_t state_q, state_d;
    logic [31:0] n_q, n_d;
    logic [31:0] word_idx_q, word_idx_d;
    logic        in_ready_q, in_ready_d;
    logic        mem_wen_q, mem_wen_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        core_rst_n_q, core_rst_n_d;
    logic        load_done_q, load_done_d;
    logic        load_err_q, load_err_d;

    logic        byte_en;
    logic        word_valid;
    logic [31:0] word;

    assign byte_en = bus.in_valid && in_ready_q;

    rv32_word_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .byte_en    (byte_en),
        .byte_in    (bus.in_data),
        .word_valid (word_valid),
        .word       (word)
    );

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        word_idx_d  = word_idx_q;
        mem_wen_d   = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            HDR: begin
                if (word_valid) begin
                    n_d     = word;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (n_q == 32'd0) begin
                    state_d = DONE;
                end else if (n_q > 32'(DEPTH_WORDS)) begin
                    state_d = ERR;
                end else begin
                    state_d    = DATA;
                    word_idx_d = '0;
                end
            end
            DATA: begin
                // The last write is still in flight while DATA is held for
                // one more cycle; the stream is already closed by in_ready.
                if (mem_wen_q && (word_idx_q == n_q)) begin
                    state_d = DONE;
                end else if (word_valid) begin
                    mem_wen_d   = 1'b1;
                    mem_addr_d  = OFFSET + {word_idx_q[29:0], 2'b00};
                    mem_wdata_d = word;
                    word_idx_d  = word_idx_q + 32'd1;
                end
            end
            DONE, ERR: begin
            end
            default: state_d = HDR;
        endcase

        // Close the stream as soon as the final word has been taken so no
        // byte is accepted during the write-out cycle.
        in_ready_d   = (state_d == HDR) ||
                       ((state_d == DATA) && (word_idx_d != n_d));
        load_done_d  = (state_d == DONE);
        core_rst_n_d = (state_d == DONE);
        load_err_d   = (state_d == ERR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= HDR;
            n_q          <= '0;
            word_idx_q   <= '0;
            in_ready_q   <= 1'b0;
            mem_wen_q    <= 1'b0;
            mem_addr_q   <= OFFSET;
            mem_wdata_q  <= '0;
            core_rst_n_q <= 1'b0;
            load_done_q  <= 1'b0;
            load_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            word_idx_q   <= word_idx_d;
            in_ready_q   <= in_ready_d;
            mem_wen_q    <= mem_wen_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            core_rst_n_q <= core_rst_n_d;
            load_done_q  <= load_done_d;
            load_err_q   <= load_err_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.mem_wen   = mem_wen_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign core_rst_n    = core_rst_n_q;
    assign load_done     = load_done_q;
    assign load_err      = load_err_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: expected writes are queued as
// bytes are driven and compared when mem_wen is seen.
module tb_imem_boot_loader;

    localparam logic [31:0] OFFSET      = 32'h8000_0000;
    localparam int unsigned DEPTH_WORDS = 4096;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic core_rst_n, load_done, load_err;

    imem_boot_loader_if bus ();

    imem_boot_loader #(
        .OFFSET      (OFFSET),
        .DEPTH_WORDS (DEPTH_WORDS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .core_rst_n (core_rst_n),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int wen_count = 0;
    logic [31:0] last_addr = '0;
    logic [63:0] exp_q[$];
    logic [63:0] mon_e;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Write monitor / scoreboard
    always @(negedge clk) begin
        if (rst_n && bus.mem_wen === 1'b1) begin
            wen_count++;
            last_addr = bus.mem_addr;
            if (exp_q.size() == 0) begin
                check_val("spurious_wen", {31'b0, bus.mem_wen}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check_val("wr_addr", bus.mem_addr, mon_e[63:32]);
                check_val("wr_data", bus.mem_wdata, mon_e[31:0]);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int cnt;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        cnt = 0;
        while (bus.in_ready !== 1'b1 && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 100) check_val("ready_timeout", {31'b0, bus.in_ready}, 32'd1);
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap);
        for (int i = 0; i < 4; i++) begin
            if (gap) begin
                @(negedge clk);
                bus.in_valid = 1'b0;
            end
            send_byte(w[8*i +: 8]);
        end
    endtask

    task automatic push_exp(input int idx, input logic [31:0] w);
        logic [31:0] a;
        a = OFFSET + 32'(idx) * 32'd4;
        exp_q.push_back({a, w});
    endtask

    task automatic check_reset_vals(input string tag);
        check_val({tag, "_ready"}, {31'b0, bus.in_ready}, 32'd0);
        check_val({tag, "_wen"}, {31'b0, bus.mem_wen}, 32'd0);
        check_val({tag, "_addr"}, bus.mem_addr, OFFSET);
        check_val({tag, "_wdata"}, bus.mem_wdata, 32'd0);
        check_val({tag, "_corerst"}, {31'b0, core_rst_n}, 32'd0);
        check_val({tag, "_done"}, {31'b0, load_done}, 32'd0);
        check_val({tag, "_err"}, {31'b0, load_err}, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Called right after the last byte has been presented: acceptance at the
    // next rising edge t, write visible in t+1, done/core release in t+2.
    task automatic check_done_latency(input string tag, input bit expect_wen);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check_val({tag, "_wen_t1"}, {31'b0, bus.mem_wen}, {31'b0, expect_wen});
        check_val({tag, "_done_t1"}, {31'b0, load_done}, 32'd0);
        check_val({tag, "_corerst_t1"}, {31'b0, core_rst_n}, 32'd0);
        @(negedge clk);
        check_val({tag, "_done_t2"}, {31'b0, load_done}, 32'd1);
        check_val({tag, "_corerst_t2"}, {31'b0, core_rst_n}, 32'd1);
        check_val({tag, "_ready_t2"}, {31'b0, bus.in_ready}, 32'd0);
        check_val({tag, "_wen_t2"}, {31'b0, bus.mem_wen}, 32'd0);
        check_val({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [31:0] w;
        int wc0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;

        // Reset state and first cycle after reset
        repeat (2) @(negedge clk);
        check_reset_vals("rst");
        rst_n = 1'b1;
        check_val("ready_first_cycle", {31'b0, bus.in_ready}, 32'd0);

        // Test 1: N=2 back-to-back
        send_word(32'd2, 1'b0);
        push_exp(0, 32'h0000_0513);
        push_exp(1, 32'h0010_0073);
        send_word(32'h0000_0513, 1'b0);
        send_word(32'h0010_0073, 1'b0);
        check_done_latency("t1", 1'b1);

        // Test 2: same image, in_valid toggling
        do_reset();
        send_word(32'd2, 1'b1);
        push_exp(0, 32'h0000_0513);
        push_exp(1, 32'h0010_0073);
        send_word(32'h0000_0513, 1'b1);
        send_word(32'h0010_0073, 1'b1);
        check_done_latency("t2", 1'b1);

        // Test 3: empty image, then Test 6: bytes after DONE
        do_reset();
        wc0 = wen_count;
        send_word(32'd0, 1'b0);
        check_done_latency("t3", 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = 8'hAA;
            check_val("t6_ready", {31'b0, bus.in_ready}, 32'd0);
            check_val("t6_corerst", {31'b0, core_rst_n}, 32'd1);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        check_val("t3_t6_wen_count", 32'(wen_count - wc0), 32'd0);

        // Test 4a: N = DEPTH_WORDS+1 -> error
        do_reset();
        wc0 = wen_count;
        send_word(DEPTH_WORDS + 1, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check_val("t4_err", {31'b0, load_err}, 32'd1);
        check_val("t4_corerst", {31'b0, core_rst_n}, 32'd0);
        check_val("t4_ready", {31'b0, bus.in_ready}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(i);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        check_val("t4_err_sticky", {31'b0, load_err}, 32'd1);
        check_val("t4_done", {31'b0, load_done}, 32'd0);
        check_val("t4_wen_count", 32'(wen_count - wc0), 32'd0);

        // Test 4b: N = DEPTH_WORDS loads fully
        do_reset();
        wc0 = wen_count;
        send_word(DEPTH_WORDS, 1'b0);
        for (int i = 0; i < int'(DEPTH_WORDS); i++) begin
            w = $urandom;
            push_exp(i, w);
            send_word(w, 1'b0);
        end
        check_done_latency("t4b", 1'b1);
        check_val("t4b_wen_count", 32'(wen_count - wc0), DEPTH_WORDS);
        check_val("t4b_last_addr", last_addr, 32'h8000_3FFC);
        check_val("t4b_err", {31'b0, load_err}, 32'd0);

        // Test 5: reset after two payload bytes, then a fresh N=1 image
        do_reset();
        wc0 = wen_count;
        send_word(32'd1, 1'b0);
        send_byte(8'h11);
        send_byte(8'h22);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_vals("t5_midrst");
        check_val("t5_wen_count", 32'(wen_count - wc0), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        send_word(32'd1, 1'b0);
        push_exp(0, 32'hDEAD_BEEF);
        send_word(32'hDEAD_BEEF, 1'b0);
        check_done_latency("t5", 1'b1);
        check_val("t5_last_addr", last_addr, 32'h8000_0000);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
